// File: rtl/mole_spawner.sv
// ---------------------------------------------------------------------------
// mole_spawner : whack-a-mole spawner with LFSR position, lifetime and scoring
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mole_spawner #(
    parameter int          LIFETIME_TICKS = 3,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        tick_i,
    input  logic        enable_i,
    input  logic [15:0] switches_i,
    output logic [15:0] LEDs_o,
    output logic        whacked_o,
    output logic        missed_o,
    output logic [7:0]  hit_count_o,
    output logic [7:0]  miss_count_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SPAWN    = 2'd1,
        S_UP       = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    localparam logic [3:0] C_LIFETIME = LIFETIME_TICKS[3:0];

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] sw_q, sw_d;
    logic [15:0] leds_q, leds_d;
    logic [3:0]  pos_q, pos_d;
    logic [3:0]  life_q, life_d;
    logic [7:0]  hit_q, hit_d;
    logic [7:0]  miss_q, miss_d;
    logic        whacked_q, whacked_d;
    logic        missed_q, missed_d;

    logic        lfsr_fb;
    logic [3:0]  candidate;
    logic [3:0]  spawn_pos;
    logic [15:0] toggle;
    logic        hit_now;

    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign candidate = lfsr_q[3:0];
    // Never light the same hole twice in a row; the 4-bit add wraps 15 -> 0.
    assign spawn_pos = (candidate == pos_q) ? candidate + 4'd1 : candidate;
    assign toggle    = switches_i ^ sw_q;
    assign hit_now   = toggle[pos_q];

    always_comb begin
        state_d   = state_q;
        lfsr_d    = enable_i ? {lfsr_q[14:0], lfsr_fb} : lfsr_q;
        sw_d      = switches_i;
        leds_d    = leds_q;
        pos_d     = pos_q;
        life_d    = life_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        whacked_d = 1'b0;
        missed_d  = 1'b0;

        if (!enable_i) begin
            state_d = S_IDLE;
            leds_d  = 16'h0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    hit_d   = 8'd0;
                    miss_d  = 8'd0;
                    leds_d  = 16'h0000;
                    pos_d   = spawn_pos;
                    state_d = S_SPAWN;
                end
                S_SPAWN: begin
                    life_d  = C_LIFETIME;
                    leds_d  = 16'h0001 << pos_q;
                    state_d = S_UP;
                end
                S_UP: begin
                    // A hit wins over an expiring tick in the same cycle.
                    if (hit_now) begin
                        whacked_d = 1'b1;
                        hit_d     = (hit_q == 8'hFF) ? hit_q : hit_q + 8'd1;
                        leds_d    = 16'h0000;
                        state_d   = S_COOLDOWN;
                    end else if (tick_i) begin
                        if (life_q <= 4'd1) begin
                            missed_d = 1'b1;
                            miss_d   = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;
                            leds_d   = 16'h0000;
                            state_d  = S_COOLDOWN;
                        end else begin
                            life_d = life_q - 4'd1;
                        end
                    end
                end
                S_COOLDOWN: begin
                    leds_d = 16'h0000;
                    if (tick_i) begin
                        pos_d   = spawn_pos;
                        state_d = S_SPAWN;
                    end
                end
                default: begin
                    leds_d  = 16'h0000;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            sw_q      <= 16'h0000;
            leds_q    <= 16'h0000;
            pos_q     <= 4'd0;
            life_q    <= 4'd0;
            hit_q     <= 8'd0;
            miss_q    <= 8'd0;
            whacked_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            sw_q      <= sw_d;
            leds_q    <= leds_d;
            pos_q     <= pos_d;
            life_q    <= life_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            whacked_q <= whacked_d;
            missed_q  <= missed_d;
        end
    end

    assign LEDs_o       = leds_q;
    assign whacked_o    = whacked_q;
    assign missed_o     = missed_q;
    assign hit_count_o  = hit_q;
    assign miss_count_o = miss_q;

endmodule

`default_nettype wire

// File: tb/tb_mole_spawner.sv
// ---------------------------------------------------------------------------
// tb_mole_spawner : directed vectors plus randomized run against a game model
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mole_spawner;

    localparam int LT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        en = 1'b0;
    logic [15:0] sw = 16'h0000;
    logic [15:0] leds;
    logic        whk;
    logic        mis;
    logic [7:0]  hc;
    logic [7:0]  mc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mole_spawner #(.LIFETIME_TICKS(LT), .LFSR_SEED(16'hACE1)) dut (
        .clock_i     (clk),
        .reset_i     (rst_n),
        .tick_i      (tick),
        .enable_i    (en),
        .switches_i  (sw),
        .LEDs_o      (leds),
        .whacked_o   (whk),
        .missed_o    (mis),
        .hit_count_o (hc),
        .miss_count_o(mc)
    );

    // Game model: which hole is lit (-1 = none), whether a spawn is pending,
    // remaining life, and the score.
    int          m_lfsr;
    int          m_prev;
    int          m_lit;
    int          m_life;
    int          m_hits;
    int          m_misses;
    bit          m_game;
    bit          m_arming;
    bit          m_w;
    bit          m_m;
    logic [15:0] m_sw;

    function automatic int lfsr_next(input int v);
        int fb;
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return ((v << 1) | fb) & 32'h0000FFFF;
    endfunction

    task automatic model_reset();
        m_lfsr = 32'h0000ACE1; m_prev = 0; m_lit = -1; m_life = 0;
        m_hits = 0; m_misses = 0; m_game = 0; m_arming = 0;
        m_w = 0; m_m = 0; m_sw = 16'h0000;
    endtask

    task automatic pick();
        int c;
        c = m_lfsr % 16;
        if (c == m_prev) c = (c + 1) % 16;
        m_prev = c;
    endtask

    task automatic model_step(input logic e, input logic t, input logic [15:0] s);
        logic [15:0] tog;
        tog = s ^ m_sw;
        m_w = 0;
        m_m = 0;
        if (!e) begin
            m_game = 0; m_arming = 0; m_lit = -1;
        end else if (!m_game) begin
            m_game = 1; m_hits = 0; m_misses = 0; pick(); m_arming = 1;
        end else if (m_arming) begin
            m_arming = 0; m_lit = m_prev; m_life = LT;
        end else if (m_lit >= 0) begin
            if (tog[m_lit]) begin
                m_w = 1; if (m_hits < 255) m_hits++; m_lit = -1;
            end else if (t) begin
                if (m_life == 1) begin
                    m_m = 1; if (m_misses < 255) m_misses++; m_lit = -1;
                end else m_life--;
            end
        end else if (t) begin
            pick(); m_arming = 1;
        end
        m_sw = s;
        if (e) m_lfsr = lfsr_next(m_lfsr);
    endtask

    function automatic logic [33:0] outs();
        return {leds, whk, mis, hc, mc};
    endfunction

    function automatic logic [33:0] exp_outs();
        logic [15:0] l;
        l = (m_lit < 0) ? 16'h0000 : (16'h0001 << m_lit);
        return {l, m_w, m_m, 8'(m_hits), 8'(m_misses)};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (leds,whk,mis,hits,misses)", name, act, exp);
    endtask

    task automatic step(input logic e, input logic t, input logic [15:0] s);
        en = e; tick = t; sw = s;
        model_step(e, t, s);
        @(negedge clk);
        check("cycle", outs(), exp_outs());
    endtask

    // Asserts reset between clock edges so the asynchronous path is what clears state.
    task automatic apply_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("async_reset", outs(), 34'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        e;
        logic        t;
        logic [15:0] s;
        logic [15:0] l;
        logic        w;
        logic        m;
        logic [7:0]  h;
        logic [7:0]  mm;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int guard;
        logic [15:0] s;

        // Default seed: first hole is lfsr[3:0]=1, the second spawn lands on 2.
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[2]  = '{1'b1, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0, 8'd0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b1, 1'b0, 8'd1, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 16'h0003, 16'h0004, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[9]  = '{1'b1, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[10] = '{1'b1, 1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 8'd1, 8'd0};
        tbl[11] = '{1'b1, 1'b1, 16'h0003, 16'h0000, 1'b0, 1'b1, 8'd1, 8'd1};
        tbl[12] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 8'd1, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 8'd1, 8'd1};
        tbl[14] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0};

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_state", outs(), 34'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            en = tbl[i].e; tick = tbl[i].t; sw = tbl[i].s;
            @(negedge clk);
            check($sformatf("vec%0d", i), outs(),
                  {tbl[i].l, tbl[i].w, tbl[i].m, tbl[i].h, tbl[i].mm});
        end

        // Nonzero switches at reset release must not register as a hit.
        sw = 16'hBEEF;
        apply_reset();
        step(1'b1, 1'b0, 16'hBEEF);
        check("no_hit_first_clock", {32'h0, whk, hc[0]}, 34'h0);
        step(1'b1, 1'b0, 16'hBEEF);
        step(1'b1, 1'b1, sw);
        step(1'b1, 1'b1, sw);
        if (m_lit >= 0) begin
            step(1'b1, 1'b1, sw ^ (16'h0001 << m_lit));
            check("simul_hit_tick", {30'h0, whk, mis, hc == 8'd1, mc == 8'd0},
                  {30'h0, 1'b1, 1'b0, 1'b1, 1'b1});
        end else begin
            check("simul_hit_setup", 34'h0, 34'h1);
        end

        // Drive hits until the counter saturates.
        guard = 0;
        while (m_hits < 255 && guard < 1500) begin
            if (m_lit >= 0) step(1'b1, 1'b0, sw ^ (16'h0001 << m_lit));
            else            step(1'b1, 1'b1, sw);
            guard++;
        end
        guard = 0;
        while (m_lit < 0 && guard < 10) begin
            step(1'b1, 1'b1, sw);
            guard++;
        end
        if (m_hits == 255 && m_lit >= 0) begin
            step(1'b1, 1'b0, sw ^ (16'h0001 << m_lit));
            check("hit_saturate", {25'h0, whk, hc}, {25'h0, 1'b1, 8'hFF});
        end else begin
            check("saturate_setup", 34'h0, 34'h1);
        end

        // Reset while a mole is lit, then toggle right after release.
        guard = 0;
        while (m_lit < 0 && guard < 10) begin
            step(1'b1, 1'b1, sw);
            guard++;
        end
        check("mole_lit_before_reset", {33'h0, leds != 16'h0}, 34'h1);
        apply_reset();
        step(1'b1, 1'b0, sw ^ 16'hFFFF);
        check("no_pulse_after_reset", {32'h0, whk, mis}, 34'h0);

        for (int i = 0; i < 3000; i++) begin
            s = sw;
            if (m_lit >= 0 && $urandom_range(0, 2) == 0) s = s ^ (16'h0001 << m_lit);
            if ($urandom_range(0, 1) == 1) s = s ^ (16'h0001 << $urandom_range(0, 15));
            step(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, s);
            check("invariants", {32'h0, $countones(leds) <= 1, !(whk && mis)}, 34'h3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
